hazard_fwd_ctrl: RTL and testbench

- Parametrised successor to the pipeline operand-forwarding unit.
- Combines EX-stage forwarding select (EX/MEM, MEM/WB) with decode-stage hazard control: multi-cycle load-use stall FSM, no-forwarding mode, taken-branch flush and a saturating stall-cycle performance counter.
- Sits beside the ID/EX pipeline registers; drives the ALU operand muxes, PC/IF-ID write enables and ID/EX bubble insertion.

---
 rtl/hazard_fwd_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Purpose  : Pipeline hazard controller.
//            - EX-stage operand forwarding select (EX/MEM over MEM/WB).
//            - Decode-stage load-use stall FSM (LOAD_LAT cycles per hazard).
//            - Stall-on-RAW operation when forwarding is disabled.
//            - Taken-branch flush, which overrides and aborts any stall.
//            - Saturating count of hazard-stall cycles.
// Ports    : clk, reset (sync, active-high)
//            IFID_*  : decode-stage source regs and use flags
//            IDEX_*  : EX-stage sources, destination, RegWrite/MemRead
//            EXMEM_* : MEM-stage destination, RegWrite/MemRead
//            MEMWB_* : WB-stage destination, RegWrite
//            branch_taken : taken branch/jump resolved in EX
//            fwd_A/fwd_B  : 00 regfile, 10 EX/MEM, 01 MEM/WB
//            pc_write, IFID_write, IDEX_bubble, IFID_flush : pipeline control
//            stall_cycles : saturating hazard-stall cycle count
// Revision : 1.0  initial release
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] IFID_rs1,
    input  logic [REG_AW-1:0] IFID_rs2,
    input  logic              IFID_use_rs1,
    input  logic              IFID_use_rs2,
    input  logic [REG_AW-1:0] IDEX_rs1,
    input  logic [REG_AW-1:0] IDEX_rs2,
    input  logic [REG_AW-1:0] IDEX_rd,
    input  logic              IDEX_RegWrite,
    input  logic              IDEX_MemRead,
    input  logic [REG_AW-1:0] EXMEM_rd,
    input  logic              EXMEM_RegWrite,
    input  logic              EXMEM_MemRead,
    input  logic [REG_AW-1:0] MEMWB_rd,
    input  logic              MEMWB_RegWrite,
    input  logic              branch_taken,
    output logic [1:0]        fwd_A,
    output logic [1:0]        fwd_B,
    output logic              pc_write,
    output logic              IFID_write,
    output logic              IDEX_bubble,
    output logic              IFID_flush,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [0:0]       c_IDLE    = 1'b0;
    localparam logic [0:0]       c_LSTALL  = 1'b1;
    localparam logic [2:0]       c_LAT_M1  = 3'(LOAD_LAT - 1);
    localparam bit               c_MULTI   = (LOAD_LAT > 1);
    localparam bit               c_FWD_ON  = (FWD_EN != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_match_ex;
    logic w_match_mem;
    logic w_lu_haz;
    logic w_raw_haz;
    logic w_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // ------------------------------------------------------------------
    // EX-stage forwarding. A load sitting in EX/MEM has no data yet, so it
    // is never a forwarding source from that stage.
    // ------------------------------------------------------------------
    function automatic logic [1:0] f_fwd_sel(input logic [REG_AW-1:0] rs,
                                             input logic [REG_AW-1:0] exmem_rd,
                                             input logic              exmem_rw,
                                             input logic              exmem_mr,
                                             input logic [REG_AW-1:0] memwb_rd,
                                             input logic              memwb_rw);
        logic [1:0] sel;
        sel = 2'b00;
        if (c_FWD_ON) begin
            if (exmem_rw && !exmem_mr && (exmem_rd != '0) && (exmem_rd == rs))
                sel = 2'b10;
            else if (memwb_rw && (memwb_rd != '0) && (memwb_rd == rs))
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign w_fwd_a = f_fwd_sel(IDEX_rs1, EXMEM_rd, EXMEM_RegWrite, EXMEM_MemRead,
                               MEMWB_rd, MEMWB_RegWrite);
    assign w_fwd_b = f_fwd_sel(IDEX_rs2, EXMEM_rd, EXMEM_RegWrite, EXMEM_MemRead,
                               MEMWB_rd, MEMWB_RegWrite);

    // ------------------------------------------------------------------
    // Decode hazards. MEM/WB is excluded: the regfile writes before read.
    // ------------------------------------------------------------------
    assign w_match_ex  = (IDEX_rd != '0) &&
                         ((IFID_use_rs1 && (IDEX_rd == IFID_rs1)) ||
                          (IFID_use_rs2 && (IDEX_rd == IFID_rs2)));
    assign w_match_mem = (EXMEM_rd != '0) &&
                         ((IFID_use_rs1 && (EXMEM_rd == IFID_rs1)) ||
                          (IFID_use_rs2 && (EXMEM_rd == IFID_rs2)));

    assign w_lu_haz  = IDEX_MemRead && IDEX_RegWrite && w_match_ex;
    assign w_raw_haz = !c_FWD_ON &&
                       ((IDEX_RegWrite && w_match_ex) || (EXMEM_RegWrite && w_match_mem));

    // Once in LSTALL the offending load has moved on and ID/EX carries
    // bubbles, so the latched state alone holds the stall.
    assign w_stall = ((r_state == c_IDLE) && (w_lu_haz || w_raw_haz)) ||
                     (r_state == c_LSTALL);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The detect cycle is spent in IDLE, so LSTALL covers
    // the remaining LOAD_LAT-1 cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (branch_taken) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_lu_haz && c_MULTI) begin
                        w_state_nxt = c_LSTALL;
                        w_cnt_nxt   = c_LAT_M1;
                    end
                end
                c_LSTALL: begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1)
                        w_state_nxt = c_IDLE;
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Priority: reset, then branch flush, then stall.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_A       = w_fwd_a;
        fwd_B       = w_fwd_b;
        pc_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        if (reset) begin
            fwd_A       = 2'b00;
            fwd_B       = 2'b00;
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
            IFID_flush  = 1'b1;
        end else if (branch_taken) begin
            IDEX_bubble = 1'b1;
            IFID_flush  = 1'b1;
        end else if (w_stall) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter; branch-aborted cycles are not stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cycles <= '0;
        else if (w_stall && !branch_taken && (r_stall_cycles != c_CNT_MAX))
            r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
    end

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_ctrl
// Purpose  : Directed self-checking bench for hazard_fwd_ctrl. Two instances:
//            u_a (FWD_EN=1, LOAD_LAT=3, CNT_W=16) and
//            u_b (FWD_EN=0, LOAD_LAT=4, CNT_W=4).
//            Expected outputs are queued as stimulus is applied and compared
//            at the following falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

    typedef struct packed {
        logic       reset;
        logic [4:0] IFID_rs1;
        logic [4:0] IFID_rs2;
        logic       IFID_use_rs1;
        logic       IFID_use_rs2;
        logic [4:0] IDEX_rs1;
        logic [4:0] IDEX_rs2;
        logic [4:0] IDEX_rd;
        logic       IDEX_RegWrite;
        logic       IDEX_MemRead;
        logic [4:0] EXMEM_rd;
        logic       EXMEM_RegWrite;
        logic       EXMEM_MemRead;
        logic [4:0] MEMWB_rd;
        logic       MEMWB_RegWrite;
        logic       branch_taken;
    } in_t;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic        fl;
        logic [15:0] cnt;
    } out_t;

    // {pc_write, IFID_write, IDEX_bubble, IFID_flush}
    localparam logic [3:0] c_RUN = 4'b1100;
    localparam logic [3:0] c_STL = 4'b0010;
    localparam logic [3:0] c_BR  = 4'b1111;
    localparam logic [3:0] c_RST = 4'b0011;

    logic clk;
    in_t  in_a;
    in_t  in_b;

    logic [1:0]  fwd_A_a, fwd_B_a, fwd_A_b, fwd_B_b;
    logic        pc_write_a, IFID_write_a, IDEX_bubble_a, IFID_flush_a;
    logic        pc_write_b, IFID_write_b, IDEX_bubble_b, IFID_flush_b;
    logic [15:0] stall_cycles_a;
    logic [3:0]  stall_cycles_b;

    out_t obs_a, obs_b;
    assign obs_a = {fwd_A_a, fwd_B_a, pc_write_a, IFID_write_a, IDEX_bubble_a,
                    IFID_flush_a, stall_cycles_a};
    assign obs_b = {fwd_A_b, fwd_B_b, pc_write_b, IFID_write_b, IDEX_bubble_b,
                    IFID_flush_b, 12'd0, stall_cycles_b};

    out_t  q_a[$];
    out_t  q_b[$];
    string t_a[$];
    string t_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    hazard_fwd_ctrl #(.REG_AW(5), .LOAD_LAT(3), .FWD_EN(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(in_a.reset),
        .IFID_rs1(in_a.IFID_rs1), .IFID_rs2(in_a.IFID_rs2),
        .IFID_use_rs1(in_a.IFID_use_rs1), .IFID_use_rs2(in_a.IFID_use_rs2),
        .IDEX_rs1(in_a.IDEX_rs1), .IDEX_rs2(in_a.IDEX_rs2), .IDEX_rd(in_a.IDEX_rd),
        .IDEX_RegWrite(in_a.IDEX_RegWrite), .IDEX_MemRead(in_a.IDEX_MemRead),
        .EXMEM_rd(in_a.EXMEM_rd), .EXMEM_RegWrite(in_a.EXMEM_RegWrite),
        .EXMEM_MemRead(in_a.EXMEM_MemRead),
        .MEMWB_rd(in_a.MEMWB_rd), .MEMWB_RegWrite(in_a.MEMWB_RegWrite),
        .branch_taken(in_a.branch_taken),
        .fwd_A(fwd_A_a), .fwd_B(fwd_B_a), .pc_write(pc_write_a),
        .IFID_write(IFID_write_a), .IDEX_bubble(IDEX_bubble_a),
        .IFID_flush(IFID_flush_a), .stall_cycles(stall_cycles_a)
    );

    hazard_fwd_ctrl #(.REG_AW(5), .LOAD_LAT(4), .FWD_EN(0), .CNT_W(4)) u_b (
        .clk(clk), .reset(in_b.reset),
        .IFID_rs1(in_b.IFID_rs1), .IFID_rs2(in_b.IFID_rs2),
        .IFID_use_rs1(in_b.IFID_use_rs1), .IFID_use_rs2(in_b.IFID_use_rs2),
        .IDEX_rs1(in_b.IDEX_rs1), .IDEX_rs2(in_b.IDEX_rs2), .IDEX_rd(in_b.IDEX_rd),
        .IDEX_RegWrite(in_b.IDEX_RegWrite), .IDEX_MemRead(in_b.IDEX_MemRead),
        .EXMEM_rd(in_b.EXMEM_rd), .EXMEM_RegWrite(in_b.EXMEM_RegWrite),
        .EXMEM_MemRead(in_b.EXMEM_MemRead),
        .MEMWB_rd(in_b.MEMWB_rd), .MEMWB_RegWrite(in_b.MEMWB_RegWrite),
        .branch_taken(in_b.branch_taken),
        .fwd_A(fwd_A_b), .fwd_B(fwd_B_b), .pc_write(pc_write_b),
        .IFID_write(IFID_write_b), .IDEX_bubble(IDEX_bubble_b),
        .IFID_flush(IFID_flush_b), .stall_cycles(stall_cycles_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue one expected output vector for instance a (which=0) or b (which=1).
    task automatic push(input bit which, input string tag, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [3:0] ctl, input int cnt);
        out_t e;
        e.fa  = fa;
        e.fb  = fb;
        {e.pcw, e.ifw, e.bub, e.fl} = ctl;
        e.cnt = 16'(cnt);
        if (which) begin
            q_b.push_back(e);
            t_b.push_back(tag);
        end else begin
            q_a.push_back(e);
            t_a.push_back(tag);
        end
    endtask

    // Compare all queued expectations mid-cycle, then advance one clock.
    task automatic tick();
        out_t  e;
        string t;
        @(negedge clk);
        while (q_a.size() > 0) begin
            e = q_a.pop_front();
            t = t_a.pop_front();
            n_tests++;
            assert (obs_a === e) else begin
                n_fail++;
                $error("FAIL a.%s: observed fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b cnt=%0d, expected fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b cnt=%0d",
                       t, obs_a.fa, obs_a.fb, obs_a.pcw, obs_a.ifw, obs_a.bub, obs_a.fl, obs_a.cnt,
                       e.fa, e.fb, e.pcw, e.ifw, e.bub, e.fl, e.cnt);
            end
        end
        while (q_b.size() > 0) begin
            e = q_b.pop_front();
            t = t_b.pop_front();
            n_tests++;
            assert (obs_b === e) else begin
                n_fail++;
                $error("FAIL b.%s: observed fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b cnt=%0d, expected fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b cnt=%0d",
                       t, obs_b.fa, obs_b.fb, obs_b.pcw, obs_b.ifw, obs_b.bub, obs_b.fl, obs_b.cnt,
                       e.fa, e.fb, e.pcw, e.ifw, e.bub, e.fl, e.cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- Reset: outputs forced, fwd masked ----------------
        in_a = '0;
        in_b = '0;
        in_a.reset = 1'b1;
        in_b.reset = 1'b1;
        in_a.IDEX_rs1 = 5'd5;
        in_a.EXMEM_rd = 5'd5;
        in_a.EXMEM_RegWrite = 1'b1;
        @(posedge clk);
        #1;
        push(0, "reset", 2'b00, 2'b00, c_RST, 0);
        push(1, "reset", 2'b00, 2'b00, c_RST, 0);
        tick();

        // ---------------- Forwarding priority (b has forwarding off) -------
        in_a = '0;
        in_a.IDEX_rs1 = 5'd5;
        in_a.EXMEM_rd = 5'd5;  in_a.EXMEM_RegWrite = 1'b1;
        in_a.MEMWB_rd = 5'd5;  in_a.MEMWB_RegWrite = 1'b1;
        in_b = in_a;
        push(0, "fwd_exmem_prio", 2'b10, 2'b00, c_RUN, 0);
        push(1, "fwd_off_1",      2'b00, 2'b00, c_RUN, 0);
        tick();

        in_a.EXMEM_RegWrite = 1'b0;
        in_a.IDEX_rs2 = 5'd5;
        in_b = in_a;
        push(0, "fwd_memwb", 2'b01, 2'b01, c_RUN, 0);
        push(1, "fwd_off_2", 2'b00, 2'b00, c_RUN, 0);
        tick();

        in_a.EXMEM_RegWrite = 1'b1;
        in_a.EXMEM_MemRead  = 1'b1;
        in_b = in_a;
        push(0, "fwd_exmem_load_skipped", 2'b01, 2'b01, c_RUN, 0);
        push(1, "fwd_off_3",              2'b00, 2'b00, c_RUN, 0);
        tick();

        in_a.EXMEM_MemRead = 1'b0;
        in_a.EXMEM_rd = 5'd21;
        in_a.MEMWB_rd = 5'd0;
        in_b = in_a;
        push(0, "fwd_full_width_compare", 2'b00, 2'b00, c_RUN, 0);
        push(1, "fwd_off_4",              2'b00, 2'b00, c_RUN, 0);
        tick();

        in_a.IDEX_rs1 = 5'd0;
        in_a.IDEX_rs2 = 5'd0;
        in_a.EXMEM_rd = 5'd0;
        in_b = in_a;
        push(0, "fwd_r0_never", 2'b00, 2'b00, c_RUN, 0);
        push(1, "fwd_off_5",    2'b00, 2'b00, c_RUN, 0);
        tick();

        // ---------------- Load with unused operand: no stall ---------------
        in_a = '0;
        in_b = '0;
        in_a.IDEX_MemRead = 1'b1;  in_a.IDEX_RegWrite = 1'b1;  in_a.IDEX_rd = 5'd7;
        in_a.IFID_rs2 = 5'd7;      in_a.IFID_use_rs2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(0, "unused_operand", 2'b00, 2'b00, c_RUN, 0);
            push(1, "idle",           2'b00, 2'b00, c_RUN, 0);
            tick();
        end

        // ---------------- Load-use, LOAD_LAT=3 on a ------------------------
        in_a.IFID_use_rs2 = 1'b1;
        push(0, "lu_detect", 2'b00, 2'b00, c_STL, 0);
        push(1, "idle",      2'b00, 2'b00, c_RUN, 0);
        tick();
        in_a.IDEX_MemRead = 1'b0;  in_a.IDEX_RegWrite = 1'b0;  in_a.IDEX_rd = 5'd0;
        push(0, "lu_stall2", 2'b00, 2'b00, c_STL, 1);
        push(1, "idle",      2'b00, 2'b00, c_RUN, 0);
        tick();
        push(0, "lu_stall3", 2'b00, 2'b00, c_STL, 2);
        push(1, "idle",      2'b00, 2'b00, c_RUN, 0);
        tick();
        push(0, "lu_release", 2'b00, 2'b00, c_RUN, 3);
        push(1, "idle",       2'b00, 2'b00, c_RUN, 0);
        tick();
        push(0, "lu_after", 2'b00, 2'b00, c_RUN, 3);
        push(1, "idle",     2'b00, 2'b00, c_RUN, 0);
        tick();

        // ---------------- No-forward RAW stall on b ------------------------
        in_a = '0;
        in_b = '0;
        in_b.EXMEM_RegWrite = 1'b1;  in_b.EXMEM_rd = 5'd4;
        in_b.MEMWB_RegWrite = 1'b1;  in_b.MEMWB_rd = 5'd4;
        in_b.IFID_rs1 = 5'd4;        in_b.IFID_use_rs1 = 1'b1;
        in_b.IDEX_rs1 = 5'd4;
        for (int i = 0; i < 3; i++) begin
            push(0, "idle",         2'b00, 2'b00, c_RUN, 3);
            push(1, "raw_stall",    2'b00, 2'b00, c_STL, i);
            tick();
        end
        in_b.EXMEM_RegWrite = 1'b0;
        push(0, "idle",              2'b00, 2'b00, c_RUN, 3);
        push(1, "raw_memwb_nohaz",   2'b00, 2'b00, c_RUN, 3);
        tick();

        // ---------------- Branch aborts load stall, LOAD_LAT=4 on b --------
        in_b = '0;
        in_b.IDEX_MemRead = 1'b1;  in_b.IDEX_RegWrite = 1'b1;  in_b.IDEX_rd = 5'd7;
        in_b.IFID_rs2 = 5'd7;      in_b.IFID_use_rs2 = 1'b1;
        push(0, "idle",      2'b00, 2'b00, c_RUN, 3);
        push(1, "br_detect", 2'b00, 2'b00, c_STL, 3);
        tick();
        in_b.IDEX_MemRead = 1'b0;  in_b.IDEX_RegWrite = 1'b0;  in_b.IDEX_rd = 5'd0;
        in_b.branch_taken = 1'b1;
        push(0, "idle",     2'b00, 2'b00, c_RUN, 3);
        push(1, "br_flush", 2'b00, 2'b00, c_BR,  4);
        tick();
        in_b = '0;
        for (int i = 0; i < 2; i++) begin
            push(0, "idle",        2'b00, 2'b00, c_RUN, 3);
            push(1, "br_aborted",  2'b00, 2'b00, c_RUN, 4);
            tick();
        end

        // ---------------- Saturation at 15 (CNT_W=4) on b -----------------
        in_b.EXMEM_RegWrite = 1'b1;  in_b.EXMEM_rd = 5'd4;
        in_b.IFID_rs1 = 5'd4;        in_b.IFID_use_rs1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            push(0, "idle",      2'b00, 2'b00, c_RUN, 3);
            push(1, "sat_stall", 2'b00, 2'b00, c_STL, (4 + k > 15) ? 15 : 4 + k);
            tick();
        end

        // ---------------- Reset mid-LSTALL on b ----------------------------
        in_b = '0;
        in_b.IDEX_MemRead = 1'b1;  in_b.IDEX_RegWrite = 1'b1;  in_b.IDEX_rd = 5'd7;
        in_b.IFID_rs2 = 5'd7;      in_b.IFID_use_rs2 = 1'b1;
        push(0, "idle",         2'b00, 2'b00, c_RUN, 3);
        push(1, "sat_lu_detect", 2'b00, 2'b00, c_STL, 15);
        tick();
        in_b.IDEX_MemRead = 1'b0;  in_b.IDEX_RegWrite = 1'b0;  in_b.IDEX_rd = 5'd0;
        push(0, "idle",          2'b00, 2'b00, c_RUN, 3);
        push(1, "sat_lstall",    2'b00, 2'b00, c_STL, 15);
        tick();
        in_b.reset = 1'b1;
        in_b.EXMEM_RegWrite = 1'b1;  in_b.EXMEM_rd = 5'd9;  in_b.IDEX_rs1 = 5'd9;
        push(0, "idle",           2'b00, 2'b00, c_RUN, 3);
        push(1, "mid_stall_reset", 2'b00, 2'b00, c_RST, 15);
        tick();
        in_b.reset = 1'b0;
        in_b.EXMEM_RegWrite = 1'b0;  in_b.EXMEM_rd = 5'd0;  in_b.IDEX_rs1 = 5'd0;
        for (int i = 0; i < 2; i++) begin
            push(0, "idle",            2'b00, 2'b00, c_RUN, 3);
            push(1, "post_reset_idle", 2'b00, 2'b00, c_RUN, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
